mem_access_ctrl: RTL and testbench

Initiator-side controller for the 16-bit data memory port. Accepts single load/store requests and block-copy requests from the datapath over a valid/ready handshake and drives the memory's shared address, write, and read-enable lines. It captures read data and returns one response per request. It sits between the CPU control/ALU stage and the data memory, and is the only driver of the memory port.

---
 rtl/mem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 16-bit data memory port: single LOAD/STORE,
// forward block COPY, one response per request over a valid/ready handshake.
module mem_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_CP_RD, S_CP_WR, S_RESP
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [DATA_W-1:0] wdata_q, cp_buf_q, rdata_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              err_q;
    logic [ADDR_W-1:0] ea;

    // Modular add: the carry out of the top bit is simply dropped.
    assign ea = req_base + req_offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Memory strobes are decoded from state so reset silences the port at once.
    always_comb begin
        state_nx        = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        OP_LOAD:  state_nx = S_LOAD;
                        OP_STORE: state_nx = S_STORE;
                        OP_COPY:  state_nx = (req_len != '0) ? S_CP_RD : S_RESP;
                        default:  state_nx = S_RESP;
                    endcase
                end
            end
            S_LOAD: begin
                mem_read        = 1'b1;
                mem_access_addr = src_q;
                state_nx        = S_RESP;
            end
            S_STORE: begin
                mem_write_en    = 1'b1;
                mem_access_addr = src_q;
                mem_write_data  = wdata_q;
                state_nx        = S_RESP;
            end
            S_CP_RD: begin
                mem_read        = 1'b1;
                mem_access_addr = src_q;
                state_nx        = S_CP_WR;
            end
            S_CP_WR: begin
                mem_write_en    = 1'b1;
                mem_access_addr = dst_q;
                mem_write_data  = cp_buf_q;
                state_nx        = (cnt_q == LEN_W'(1)) ? S_RESP : S_CP_RD;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // src_q doubles as the LOAD/STORE effective address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            wdata_q  <= '0;
            cp_buf_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    src_q   <= ea;
                    dst_q   <= req_dst;
                    wdata_q <= req_wdata;
                    cnt_q   <= req_len;
                    rdata_q <= '0;
                    err_q   <= (req_op == OP_RSVD);
                end
                S_LOAD:  rdata_q  <= mem_read_data;
                S_CP_RD: cp_buf_q <= mem_read_data;
                S_CP_WR: begin
                    src_q <= src_q + ADDR_W'(1);
                    dst_q <= dst_q + ADDR_W'(1);
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) rdata_q <= cp_buf_q;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboarded bench for mem_access_ctrl with a 256-word behavioural memory and
// a separate reference image updated at stimulus time.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_op;
    logic [15:0] req_base, req_offset, req_wdata, req_dst;
    logic [3:0]  req_len;
    logic [15:0] rsp_rdata, mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .req_dst(req_dst), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    int          wr_cnt = 0, rd_cnt = 0;
    logic [15:0] last_wr_addr = '0, last_rd_addr = '0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    assign mem_read_data = mem[mem_access_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_access_addr[7:0]] <= mem_write_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_access_addr;
        end
        if (mem_read) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_access_addr;
        end
    end

    always @(negedge clk) chk("rd_wr_excl", 32'(mem_read & mem_write_en), 32'd0);

    // Drive one request, model it, then wait for and score its response.
    // hold > 0 keeps rsp_ready low that many cycles while a stray request is offered.
    task automatic do_req(input logic [1:0] op, input logic [15:0] base, input logic [15:0] off,
                          input logic [15:0] wd, input logic [15:0] dst, input logic [3:0] len,
                          input int hold);
        logic [15:0] ea, s, d;
        exp_t        e, got;
        int          lat, w0;
        ea = base + off;
        e.rdata = '0; e.err = 1'b0; e.lat = 2;
        case (op)
            2'b00: e.rdata = ref_mem[ea[7:0]];
            2'b01: ref_mem[ea[7:0]] = wd;
            2'b10: begin
                e.lat = 1 + 2 * int'(len);
                for (int i = 0; i < int'(len); i++) begin
                    s = ea + 16'(i);
                    d = dst + 16'(i);
                    ref_mem[d[7:0]] = ref_mem[s[7:0]];
                    e.rdata = ref_mem[s[7:0]];
                end
            end
            default: begin e.err = 1'b1; e.lat = 1; end
        endcase
        sb_q.push_back(e);

        @(negedge clk);
        req_op = op; req_base = base; req_offset = off; req_wdata = wd;
        req_dst = dst; req_len = len; req_valid = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end

        w0 = wr_cnt;
        for (int h = 0; h < hold; h++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            req_op = 2'b01; req_base = 16'h00F0; req_offset = '0;
            req_wdata = 16'hDEAD; req_valid = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (hold > 0) chk("bp_no_write", 32'(wr_cnt - w0), 32'd0);

        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(got.err));
            chk("rsp_latency", 32'(lat), 32'(got.lat));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_taken", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int          r0, w0, n;
        logic [15:0] rb, ro, rw;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i) ^ 16'hA500;
            ref_mem[i] = 16'(i) ^ 16'hA500;
        end
        for (int i = 0; i < 3; i++) begin
            mem[i]     = 16'h1111 * 16'(i + 1);
            ref_mem[i] = 16'h1111 * 16'(i + 1);
        end
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_op = '0;
        req_base = '0; req_offset = '0; req_wdata = '0; req_dst = '0; req_len = '0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_strobes", 32'({mem_read, mem_write_en}), 32'd0);
        chk("rst_mem_addr", 32'(mem_access_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        w0 = wr_cnt;
        do_req(2'b01, 16'h0002, 16'h0001, 16'hBEEF, '0, '0, 0);
        chk("store_one_write", 32'(wr_cnt - w0), 32'd1);
        chk("store_addr", 32'(last_wr_addr), 32'h0003);
        do_req(2'b00, 16'h0002, 16'h0001, '0, '0, '0, 0);

        do_req(2'b10, 16'h0000, 16'h0000, '0, 16'h0004, 4'd3, 0);
        chk("copy_w4", 32'(mem[4]), 32'h1111);
        chk("copy_w6", 32'(mem[6]), 32'h3333);

        do_req(2'b00, 16'hFFFF, 16'h0002, '0, '0, '0, 0);
        chk("wrap_addr", 32'(last_rd_addr), 32'h0001);

        r0 = rd_cnt; w0 = wr_cnt;
        do_req(2'b10, 16'h0010, 16'h0000, '0, 16'h0030, 4'd0, 0);
        do_req(2'b11, 16'h0010, 16'h0000, '0, 16'h0030, 4'd5, 0);
        chk("noaccess_rd", 32'(rd_cnt - r0), 32'd0);
        chk("noaccess_wr", 32'(wr_cnt - w0), 32'd0);

        do_req(2'b00, 16'h0005, 16'h0000, '0, '0, '0, 5);
        do_req(2'b10, 16'h0000, 16'h0000, '0, 16'h0001, 4'd3, 0);

        // Reset lands while CP_WR is presenting the third word of a 4-word copy.
        @(negedge clk);
        req_op = 2'b10; req_base = 16'h0010; req_offset = '0;
        req_dst = 16'h0020; req_len = 4'd4; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        w0 = wr_cnt;
        n = 0;
        while (!(mem_write_en && (wr_cnt - w0) == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_copy_reach_w2", 32'(n < 50), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", 32'({mem_read, mem_write_en}), 32'd0);
        chk("midrst_addr_data", 32'({mem_access_addr, mem_write_data}), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        ref_mem[8'h20] = ref_mem[8'h10];
        ref_mem[8'h21] = ref_mem[8'h11];
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        for (int k = 0; k < 20; k++) begin
            rb = 16'h0040 + 16'($urandom_range(0, 31));
            ro = 16'($urandom_range(0, 31));
            rw = 16'($urandom);
            do_req(2'($urandom_range(0, 1)), rb, ro, rw, '0, '0, 0);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < 256; i++) chk($sformatf("mem_%0h", i), 32'(mem[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
